// File: rtl/uart_tx_engine.sv
// UART transmitter: 5..8 data bits, optional odd/even parity, 1 or 2 stop bits, runtime baud divisor.
// Define UART_TX_CTS_EN to gate new frames on a synchronized CTS input.
module uart_tx_engine #(
  parameter int P_DIV_WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             i_user_tx_data,
  input  logic                   i_user_tx_valid,
  output logic                   o_user_tx_ready,
  input  logic [P_DIV_WIDTH-1:0] i_div_num,
  input  logic [3:0]             i_data_bit,
  input  logic [1:0]             i_stop_bit,
  input  logic [1:0]             i_check_bit,
  input  logic                   i_uart_cts,
  output logic                   o_uart_tx,
  output logic                   o_busy
);
  localparam logic [P_DIV_WIDTH-1:0] DIV_ONE = 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [P_DIV_WIDTH-1:0] div_q, cnt;
  logic [7:0]             sh_q;
  logic [3:0]             nbits_q, bit_cnt;
  logic                   two_stop_q, par_en_q, par_q;
  logic                   cts_block;

`ifdef UART_TX_CTS_EN
  logic cts_s1, cts_s2;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cts_s1 <= 1'b0;
      cts_s2 <= 1'b0;
    end else begin
      cts_s1 <= i_uart_cts;
      cts_s2 <= cts_s1;
    end
  end
  assign cts_block = cts_s2;
`else
  logic unused_cts;
  assign unused_cts = i_uart_cts;
  assign cts_block  = 1'b0;
`endif

  // Frame parameters resolved at accept time so the FSM only sees clean values.
  logic [3:0] n_in;
  logic [7:0] data_masked;
  logic       bit_end, stop_last;

  always_comb begin
    n_in = i_data_bit;
    if (i_data_bit < 4'd5) n_in = 4'd5;
    else if (i_data_bit > 4'd8) n_in = 4'd8;
    data_masked = i_user_tx_data & (8'hFF >> (4'd8 - n_in));
  end

  assign bit_end   = (cnt == div_q - DIV_ONE);
  assign stop_last = two_stop_q ? (bit_cnt == 4'd1) : 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      o_uart_tx       <= 1'b1;
      o_user_tx_ready <= 1'b0;
      o_busy          <= 1'b0;
      div_q           <= '0;
      cnt             <= '0;
      sh_q            <= '0;
      nbits_q         <= '0;
      bit_cnt         <= '0;
      two_stop_q      <= 1'b0;
      par_en_q        <= 1'b0;
      par_q           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_uart_tx       <= 1'b1;
          o_busy          <= 1'b0;
          o_user_tx_ready <= !cts_block;
          if (i_user_tx_valid && o_user_tx_ready) begin
            state           <= START;
            o_uart_tx       <= 1'b0;
            o_busy          <= 1'b1;
            o_user_tx_ready <= 1'b0;
            cnt             <= '0;
            bit_cnt         <= '0;
            div_q           <= (i_div_num == '0) ? DIV_ONE : i_div_num;
            sh_q            <= data_masked;
            nbits_q         <= n_in;
            two_stop_q      <= (i_stop_bit == 2'd2);
            par_en_q        <= (i_check_bit == 2'd1) || (i_check_bit == 2'd2);
            par_q           <= (i_check_bit == 2'd1) ? ~(^data_masked) : ^data_masked;
          end
        end
        default: begin
          if (!bit_end) begin
            cnt <= cnt + DIV_ONE;
          end else begin
            cnt <= '0;
            case (state)
              START: begin
                state     <= DATA;
                o_uart_tx <= sh_q[0];
                sh_q      <= sh_q >> 1;
                bit_cnt   <= '0;
              end
              DATA: begin
                if (bit_cnt == nbits_q - 4'd1) begin
                  bit_cnt <= '0;
                  if (par_en_q) begin
                    state     <= PARITY;
                    o_uart_tx <= par_q;
                  end else begin
                    state     <= STOP;
                    o_uart_tx <= 1'b1;
                  end
                end else begin
                  bit_cnt   <= bit_cnt + 4'd1;
                  o_uart_tx <= sh_q[0];
                  sh_q      <= sh_q >> 1;
                end
              end
              PARITY: begin
                state     <= STOP;
                o_uart_tx <= 1'b1;
              end
              STOP: begin
                if (stop_last) begin
                  state           <= IDLE;
                  o_busy          <= 1'b0;
                  o_user_tx_ready <= !cts_block;
                  bit_cnt         <= '0;
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end
              default: begin
                state     <= IDLE;
                o_uart_tx <= 1'b1;
                o_busy    <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end
endmodule
